// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher for 128/192/256-bit keys.
// Each round takes five cycles: four cycles push one state word per cycle
// through a shared external inverse S-box, then one cycle performs
// AddRoundKey, InvMixColumns and InvShiftRows. Round keys come from an
// external key memory that is indexed by the round output.
module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CTR_W   = 4;
  localparam int unsigned SWORD_W = 2;

  localparam logic [CTR_W-1:0] NR_128 = CTR_W'(10);
  localparam logic [CTR_W-1:0] NR_192 = CTR_W'(12);
  localparam logic [CTR_W-1:0] NR_256 = CTR_W'(14);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CTR_W-1:0]     round_ctr_q, round_ctr_d;
  logic [SWORD_W-1:0]   sword_ctr_q, sword_ctr_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic                 ready_q, ready_d;
  logic [WORD_W-1:0]    sboxw_c;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] gm0b(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] gm0d(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] gm0e(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  // InvMixColumns on one column; byte 0 (row 0) is the most significant.
  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    m0 = gm0e(b0) ^ gm0b(b1) ^ gm0d(b2) ^ gm09(b3);
    m1 = gm09(b0) ^ gm0e(b1) ^ gm0b(b2) ^ gm0d(b3);
    m2 = gm0d(b0) ^ gm09(b1) ^ gm0e(b2) ^ gm0b(b3);
    m3 = gm0b(b0) ^ gm0d(b1) ^ gm09(b2) ^ gm0e(b3);
    return {m0, m1, m2, m3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
  endfunction

  // Row r rotated right by r: output word j, row r comes from word (j-r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] o0, o1, o2, o3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    o0 = {w0[31:24], w3[23:16], w2[15:8], w1[7:0]};
    o1 = {w1[31:24], w0[23:16], w3[15:8], w2[7:0]};
    o2 = {w2[31:24], w1[23:16], w0[15:8], w3[7:0]};
    o3 = {w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    return {o0, o1, o2, o3};
  endfunction

  // Round count from key length; the unused encoding falls back to 128-bit.
  function automatic logic [CTR_W-1:0] num_rounds(input logic [1:0] kl);
    logic [CTR_W-1:0] nr;
    case (kl)
      2'd1:    nr = NR_192;
      2'd2:    nr = NR_256;
      default: nr = NR_128;
    endcase
    return nr;
  endfunction

  // State register and datapath flops; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      round_ctr_q <= '0;
      sword_ctr_q <= '0;
      block_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      block_q     <= block_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state, datapath update and S-box word selection.
  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    block_d     = block_q;
    ready_d     = ready_q;
    sboxw_c     = '0;

    case (state_q)
      ST_IDLE: begin
        if (next) begin
          round_ctr_d = num_rounds(keylen);
          ready_d     = 1'b0;
          state_d     = ST_INIT;
        end
      end

      ST_INIT: begin
        block_d     = inv_shift_rows(block ^ round_key);
        round_ctr_d = round_ctr_q - CTR_W'(1);
        sword_ctr_d = '0;
        state_d     = ST_SBOX;
      end

      ST_SBOX: begin
        case (sword_ctr_q)
          2'd0: begin
            sboxw_c          = block_q[127:96];
            block_d[127:96]  = new_sboxw;
          end
          2'd1: begin
            sboxw_c          = block_q[95:64];
            block_d[95:64]   = new_sboxw;
          end
          2'd2: begin
            sboxw_c          = block_q[63:32];
            block_d[63:32]   = new_sboxw;
          end
          default: begin
            sboxw_c          = block_q[31:0];
            block_d[31:0]    = new_sboxw;
          end
        endcase
        sword_ctr_d = sword_ctr_q + SWORD_W'(1);
        if (sword_ctr_q == SWORD_W'(3)) begin
          state_d = ST_MAIN;
        end
      end

      ST_MAIN: begin
        if (round_ctr_q != '0) begin
          block_d     = inv_shift_rows(inv_mix_columns(block_q ^ round_key));
          round_ctr_d = round_ctr_q - CTR_W'(1);
          sword_ctr_d = '0;
          state_d     = ST_SBOX;
        end else begin
          block_d = block_q ^ round_key;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign round     = round_ctr_q;
  assign sboxw     = sboxw_c;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block using the FIPS-197 appendix C vectors.
// The bench supplies the key memory and inverse S-box from its own model.
module tb_aes_decipher_block;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic [1:0]   keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int n_checks;
  int n_fail;

  logic [7:0]   sb     [256];
  logic [7:0]   inv_sb [256];
  logic [127:0] rk     [16];

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_decipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key memory and inverse S-box, both combinational.
  assign round_key = rk[round];
  assign new_sboxw = {inv_sb[sboxw[31:24]], inv_sb[sboxw[23:16]],
                      inv_sb[sboxw[15:8]],  inv_sb[sboxw[7:0]]};

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from the field inverse plus affine map; inverse by table flip.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
        end
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[a]     = s;
      inv_sb[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Standard AES key expansion into rk[0..Nr].
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Present a start request and return just after the accepting edge.
  task automatic start_op(input logic [127:0] ct, input logic [1:0] kl, input bit hold, input string tag);
    @(negedge clk);
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_accept_ready"}, 128'(ready), 128'(1'b0));
    if (!hold) next = 1'b0;
  endtask

  // Wait for completion, checking latency, idle S-box port and optionally round order.
  task automatic wait_done(input int nr, input string tag, input bit chk_round, input int glitch_at);
    int cyc;
    int bad;
    cyc = 0;
    bad = 0;
    while (!ready && cyc < 400) begin
      if ((cyc == 0 || (cyc - 1) % 5 == 4) && sboxw != 32'h0) bad++;
      if (chk_round && cyc % 5 == 0 && cyc / 5 <= nr)
        check_eq($sformatf("%s_round_%0d", tag, cyc / 5), 128'(round), 128'(nr - cyc / 5));
      if (glitch_at != 0 && cyc == glitch_at) begin
        next   = 1'b1;
        keylen = ~keylen;
      end else if (glitch_at != 0 && cyc == glitch_at + 1) begin
        next = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 128'(cyc), 128'(5*nr + 1));
    check_eq({tag, "_sboxw_idle"}, 128'(bad), 128'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    next     = 1'b0;
    keylen   = 2'd0;
    block    = '0;
    build_sbox();
    check_eq("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));
    expand_key(KEY128, 4);

    // Reset state
    #12;
    check_eq("rst_new_block", new_block, 128'h0);
    check_eq("rst_ready", 128'(ready), 128'(1'b1));
    check_eq("rst_round", 128'(round), 128'(0));
    check_eq("rst_sboxw", 128'(sboxw), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Test 1: AES-128
    start_op(CT128, 2'd0, 1'b0, "t1");
    wait_done(10, "t1", 1'b0, 0);
    check_eq("t1_pt", new_block, PT);

    // Test 2: AES-192 with round order
    expand_key(KEY192, 6);
    start_op(CT192, 2'd1, 1'b0, "t2");
    wait_done(12, "t2", 1'b1, 0);
    check_eq("t2_pt", new_block, PT);
    check_eq("t2_round_after", 128'(round), 128'(0));

    // Test 3: AES-256, then keylen=3 behaves as 128
    expand_key(KEY256, 8);
    start_op(CT256, 2'd2, 1'b0, "t3");
    wait_done(14, "t3", 1'b0, 0);
    check_eq("t3_pt", new_block, PT);
    expand_key(KEY128, 4);
    start_op(CT128, 2'd3, 1'b0, "t3k3");
    wait_done(10, "t3k3", 1'b0, 0);
    check_eq("t3k3_pt", new_block, PT);

    // Test 4: mid-run start pulse and keylen change are ignored
    start_op(CT128, 2'd0, 1'b0, "t4");
    wait_done(10, "t4", 1'b0, 20);
    check_eq("t4_pt", new_block, PT);
    @(posedge clk);
    #1;
    check_eq("t4_no_restart", 128'(ready), 128'(1'b1));
    check_eq("t4_hold", new_block, PT);

    // Test 5: asynchronous reset mid-run, then a clean run
    start_op(CT128, 2'd0, 1'b0, "t5");
    repeat (29) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_new_block", new_block, 128'h0);
    check_eq("t5_rst_ready", 128'(ready), 128'(1'b1));
    check_eq("t5_rst_round", 128'(round), 128'(0));
    check_eq("t5_rst_sboxw", 128'(sboxw), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    start_op(CT128, 2'd0, 1'b0, "t5b");
    wait_done(10, "t5b", 1'b0, 0);
    check_eq("t5b_pt", new_block, PT);

    // Test 6: next held high across two back-to-back operations
    start_op(CT128, 2'd0, 1'b1, "t6a");
    fork
      wait_done(10, "t6a", 1'b0, 0);
      begin
        repeat (10) @(posedge clk);
        #2;
        block  = CT256;
        keylen = 2'd2;
      end
    join
    check_eq("t6a_pt", new_block, PT);
    expand_key(KEY256, 8);
    @(posedge clk);
    #1;
    check_eq("t6_ready_pulse", 128'(ready), 128'(1'b0));
    next = 1'b0;
    wait_done(14, "t6b", 1'b0, 0);
    check_eq("t6b_pt", new_block, PT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
